// File: rtl/spi_sram_slave.sv
// Behavioural 64 KB SPI SRAM slave (23LC512-style READ/WRITE/RDMR/WRMR).
// SPI pins are oversampled on HCLK through 2-flop synchronisers; single clock domain.
//
// state   | meaning
// IDLE    | deselected, waiting for cs_n low
// CMD     | shifting in the 8-bit command
// ADDR    | shifting in the 16-bit address
// DATA_RD | streaming array bytes out on so
// DATA_WR | assembling bytes from si and writing them
// MODE_RD | streaming {mode,6'b0} out on so
// MODE_WR | capturing the new mode byte
// IGNORE  | inactive until cs_n rises
module spi_sram_slave #(
  parameter int ADDR_WIDTH = 16,
  parameter int PAGE_SIZE  = 32
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic sck,
  input  logic cs_n,
  input  logic si,
  input  logic hold_n,
  output logic so,
  output logic so_oe
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA_RD, DATA_WR, MODE_RD, MODE_WR, IGNORE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PAGE_MASK = ADDR_WIDTH'(PAGE_SIZE - 1);

  logic [1:0]            r_sck_s, r_cs_s, r_si_s, r_hold_s;
  logic                  r_sck_d;
  state_t                r_state, w_next_state;
  logic [3:0]            r_bit_cnt;
  logic [2:0]            r_out_cnt;
  logic [14:0]           r_sr_in;
  logic [7:0]            r_sr_out;
  logic                  r_so, r_so_oe;
  logic [1:0]            r_mode;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_is_read, r_byte_done;
  logic [7:0]            r_mem [2**ADDR_WIDTH];

  logic                  w_sck, w_cs_n, w_si, w_hold_n, w_active, w_rise, w_fall;
  logic [7:0]            w_in_byte, w_load_byte;
  logic [15:0]           w_addr_word;
  logic                  w_byte_mode, w_mem_we;
  logic [ADDR_WIDTH-1:0] w_addr_inc, w_addr_next;

  assign w_sck       = r_sck_s[1];
  assign w_cs_n      = r_cs_s[1];
  assign w_si        = r_si_s[1];
  assign w_hold_n    = r_hold_s[1];
  assign w_active    = ~w_cs_n & w_hold_n;
  assign w_rise      = w_active & w_sck & ~r_sck_d;
  assign w_fall      = w_active & ~w_sck & r_sck_d;
  assign w_in_byte   = {r_sr_in[6:0], w_si};
  assign w_addr_word = {r_sr_in, w_si};
  // Modes 00 and 11 both behave as single-byte mode.
  assign w_byte_mode = (r_mode[1] == r_mode[0]);
  assign w_addr_inc  = r_addr + ADDR_WIDTH'(1);
  assign w_addr_next = (r_mode == 2'b10) ? ((r_addr & ~PAGE_MASK) | (w_addr_inc & PAGE_MASK))
                                         : w_addr_inc;
  assign w_load_byte = (r_state == MODE_RD) ? {r_mode, 6'b000000} : r_mem[r_addr];
  assign w_mem_we    = w_rise && (r_state == DATA_WR) && (r_bit_cnt == 4'd7);

  assign so    = r_so;
  assign so_oe = r_so_oe & w_active;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sck_s  <= 2'b00;
      r_cs_s   <= 2'b11;
      r_si_s   <= 2'b00;
      r_hold_s <= 2'b11;
      r_sck_d  <= 1'b0;
    end else begin
      r_sck_s  <= {r_sck_s[0], sck};
      r_cs_s   <= {r_cs_s[0], cs_n};
      r_si_s   <= {r_si_s[0], si};
      r_hold_s <= {r_hold_s[0], hold_n};
      r_sck_d  <= r_sck_s[1];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_cs_n) begin
      w_next_state = IDLE;
    end else if (w_hold_n) begin
      case (r_state)
        IDLE, CMD: begin
          w_next_state = CMD;
          if (w_rise && r_bit_cnt == 4'd7) begin
            case (w_in_byte)
              8'h03, 8'h02: w_next_state = ADDR;
              8'h05:        w_next_state = MODE_RD;
              8'h01:        w_next_state = MODE_WR;
              default:      w_next_state = IGNORE;
            endcase
          end
        end
        ADDR:
          if (w_rise && r_bit_cnt == 4'd15) w_next_state = r_is_read ? DATA_RD : DATA_WR;
        DATA_RD:
          if (w_fall && r_out_cnt == 3'd0 && r_byte_done && w_byte_mode) w_next_state = IGNORE;
        DATA_WR:
          if (w_rise && r_bit_cnt == 4'd7 && w_byte_mode) w_next_state = IGNORE;
        MODE_WR:
          if (w_rise && r_bit_cnt == 4'd7) w_next_state = IGNORE;
        MODE_RD, IGNORE: w_next_state = r_state;
        default: w_next_state = IGNORE;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_bit_cnt   <= 4'd0;
      r_out_cnt   <= 3'd0;
      r_sr_in     <= '0;
      r_sr_out    <= 8'h00;
      r_so        <= 1'b0;
      r_so_oe     <= 1'b0;
      r_mode      <= 2'b01;
      r_addr      <= '0;
      r_is_read   <= 1'b0;
      r_byte_done <= 1'b0;
    end else if (w_cs_n) begin
      r_bit_cnt   <= 4'd0;
      r_out_cnt   <= 3'd0;
      r_so_oe     <= 1'b0;
      r_byte_done <= 1'b0;
    end else if (w_hold_n) begin
      if (w_rise) begin
        r_sr_in   <= {r_sr_in[13:0], w_si};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      case (r_state)
        IDLE, CMD:
          if (w_rise && r_bit_cnt == 4'd7) begin
            r_bit_cnt <= 4'd0;
            r_is_read <= (w_in_byte == 8'h03);
          end
        ADDR:
          if (w_rise && r_bit_cnt == 4'd15) begin
            r_bit_cnt <= 4'd0;
            r_addr    <= w_addr_word[ADDR_WIDTH-1:0];
          end
        DATA_WR:
          if (w_rise && r_bit_cnt == 4'd7) begin
            r_bit_cnt <= 4'd0;
            r_addr    <= w_addr_next;
          end
        MODE_WR:
          if (w_rise && r_bit_cnt == 4'd7) begin
            r_bit_cnt <= 4'd0;
            r_mode    <= w_in_byte[7:6];
          end
        DATA_RD, MODE_RD:
          if (w_fall) begin
            // Falling edge with out_cnt==0 starts a new byte; byte mode stops after the first.
            if (r_out_cnt == 3'd0) begin
              if (r_state == DATA_RD && r_byte_done && w_byte_mode) begin
                r_so_oe <= 1'b0;
              end else begin
                r_so      <= w_load_byte[7];
                r_sr_out  <= {w_load_byte[6:0], 1'b0};
                r_so_oe   <= 1'b1;
                r_out_cnt <= 3'd1;
              end
            end else begin
              r_so      <= r_sr_out[7];
              r_sr_out  <= {r_sr_out[6:0], 1'b0};
              r_out_cnt <= r_out_cnt + 3'd1;
              if (r_out_cnt == 3'd7 && r_state == DATA_RD) begin
                r_addr      <= w_addr_next;
                r_byte_done <= 1'b1;
              end
            end
          end
        default: ;
      endcase
    end
  end

  // Array is intentionally left out of reset so contents survive HRESETn.
  always_ff @(posedge HCLK) begin
    if (w_mem_we) r_mem[r_addr] <= w_in_byte;
  end

endmodule

// File: tb/tb_spi_sram_slave.sv
// Self-checking bench for spi_sram_slave: directed protocol cases plus random
// write/read-back traffic against a byte-array reference model.
module tb_spi_sram_slave;
  localparam int HALF = 6;

  logic HCLK = 1'b0;
  logic HRESETn, sck, cs_n, si, hold_n;
  logic so, so_oe;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_mem [65536];
  bit         m_vld [65536];
  logic [1:0] m_mode;
  logic [7:0] q_data [$];

  spi_sram_slave #(.ADDR_WIDTH(16), .PAGE_SIZE(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .sck(sck), .cs_n(cs_n),
    .si(si), .hold_n(hold_n), .so(so), .so_oe(so_oe)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic r, output logic oe);
    si = b;
    tick(HALF);
    r  = so;
    oe = so_oe;
    sck = 1'b1;
    tick(HALF);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx,
                          output logic oe_all, output logic oe_any);
    logic r, oe;
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r, oe);
      rx[i]  = r;
      oe_all = oe_all & oe;
      oe_any = oe_any | oe;
    end
  endtask

  task automatic spi_send(input logic [7:0] tx);
    logic [7:0] rx;
    logic a, b;
    spi_byte(tx, rx, a, b);
  endtask

  task automatic spi_start();
    cs_n = 1'b0;
    tick(HALF);
  endtask

  task automatic spi_end();
    tick(HALF);
    cs_n = 1'b1;
    tick(2 * HALF);
  endtask

  function automatic bit m_byte_mode();
    return (m_mode == 2'b00) || (m_mode == 2'b11);
  endfunction

  function automatic logic [15:0] m_next(input logic [15:0] a);
    int v;
    if (m_mode == 2'b10) v = (int'(a) / 32) * 32 + ((int'(a) % 32) + 1) % 32;
    else                 v = (int'(a) + 1) % 65536;
    return 16'(v);
  endfunction

  task automatic do_write(input logic [15:0] a);
    logic [15:0] p;
    spi_start();
    spi_send(8'h02);
    spi_send(a[15:8]);
    spi_send(a[7:0]);
    foreach (q_data[i]) spi_send(q_data[i]);
    spi_end();
    p = a;
    for (int i = 0; i < q_data.size(); i++) begin
      if (m_byte_mode() && i > 0) break;
      m_mem[p] = q_data[i];
      m_vld[p] = 1'b1;
      p = m_next(p);
    end
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input int n);
    logic [7:0]  rx;
    logic        oa, oy;
    logic [15:0] p;
    p = a;
    spi_start();
    spi_send(8'h03);
    spi_send(a[15:8]);
    spi_send(a[7:0]);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, rx, oa, oy);
      if (m_byte_mode() && i > 0) begin
        check_eq({tag, "_oe_off"}, 32'(oy), 32'd0);
      end else begin
        check_eq({tag, "_oe"}, 32'(oa), 32'd1);
        if (m_vld[p]) check_eq(tag, 32'(rx), 32'(m_mem[p]));
      end
      p = m_next(p);
    end
    spi_end();
  endtask

  task automatic do_wrmr(input logic [1:0] m);
    logic [5:0] junk;
    junk = 6'($urandom);
    spi_start();
    spi_send(8'h01);
    spi_send({m, junk});
    spi_end();
    m_mode = m;
  endtask

  task automatic do_rdmr(input string tag);
    logic [7:0] rx;
    logic       oa, oy;
    spi_start();
    spi_send(8'h05);
    for (int k = 0; k < 2; k++) begin
      spi_byte(8'h00, rx, oa, oy);
      check_eq(tag, 32'(rx), 32'({m_mode, 6'b000000}));
      check_eq({tag, "_oe"}, 32'(oa), 32'd1);
    end
    tick(HALF);
    cs_n = 1'b1;
    tick(3);
    check_eq({tag, "_cs_oe"}, 32'(so_oe), 32'd0);
    tick(2 * HALF);
  endtask

  initial begin
    logic [7:0]  rx;
    logic        r, oe, oa, oy;
    logic [15:0] a;
    logic [1:0]  m;
    int          n;

    HRESETn = 1'b0; cs_n = 1'b1; sck = 1'b0; si = 1'b0; hold_n = 1'b1;
    m_mode = 2'b01;
    tick(3);
    check_eq("rst_so", 32'(so), 32'd0);
    check_eq("rst_so_oe", 32'(so_oe), 32'd0);
    HRESETn = 1'b1;
    tick(4);

    do_rdmr("rdmr_rst");

    q_data = '{8'hA5, 8'h5A};
    do_write(16'h0010);
    do_read("rd_0010", 16'h0010, 2);
    do_read("rd_0011", 16'h0011, 1);

    q_data = '{8'h11, 8'h22};
    do_write(16'hFFFF);
    do_read("rd_ffff", 16'hFFFF, 1);
    do_read("rd_0000", 16'h0000, 1);

    q_data = '{8'hC3}; do_write(16'h0020);
    q_data = '{8'h9E}; do_write(16'h0101);
    q_data = '{8'h77}; do_write(16'h0200);

    do_wrmr(2'b10);
    q_data = '{8'h33, 8'h44};
    do_write(16'h001F);
    do_read("pg_001f", 16'h001F, 1);
    do_read("pg_0000", 16'h0000, 1);
    do_read("pg_0020", 16'h0020, 1);
    do_rdmr("rdmr_page");

    do_wrmr(2'b00);
    q_data = '{8'h55, 8'h66};
    do_write(16'h0100);
    do_read("byte_0100", 16'h0100, 2);
    do_wrmr(2'b01);
    do_read("byte_0101", 16'h0101, 1);

    spi_start();
    spi_send(8'h02); spi_send(8'h02); spi_send(8'h00);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, r, oe);
    spi_end();
    do_read("abort_0200", 16'h0200, 1);

    spi_start();
    spi_send(8'hFF);
    spi_byte(8'h00, rx, oa, oy);
    check_eq("badcmd_oe", 32'(oy), 32'd0);
    spi_end();

    spi_start();
    spi_send(8'h03); spi_send(8'h00); spi_send(8'h10);
    oa = 1'b1;
    for (int i = 7; i >= 5; i--) begin
      spi_bit(1'b0, r, oe); rx[i] = r; oa = oa & oe;
    end
    tick(HALF);
    hold_n = 1'b0;
    tick(HALF);
    for (int k = 0; k < 8; k++) begin
      sck = 1'b1; tick(HALF);
      check_eq("hold_oe", 32'(so_oe), 32'd0);
      sck = 1'b0; tick(HALF);
    end
    hold_n = 1'b1;
    tick(HALF);
    for (int i = 4; i >= 0; i--) begin
      spi_bit(1'b0, r, oe); rx[i] = r; oa = oa & oe;
    end
    check_eq("hold_data", 32'(rx), 32'(m_mem[16'h0010]));
    check_eq("hold_run_oe", 32'(oa), 32'd1);
    spi_end();

    do_wrmr(2'b10);
    spi_start();
    spi_send(8'h03); spi_send(8'h00); spi_send(8'h10);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, r, oe);
    tick(2);
    HRESETn = 1'b0;
    tick(2);
    check_eq("hrst_oe", 32'(so_oe), 32'd0);
    check_eq("hrst_so", 32'(so), 32'd0);
    HRESETn = 1'b1;
    m_mode = 2'b01;
    tick(2);
    cs_n = 1'b1;
    tick(2 * HALF);
    do_rdmr("rdmr_after_hrst");
    do_read("hrst_mem_kept", 16'h0010, 1);

    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 3))
        0:       m = 2'b00;
        1:       m = 2'b10;
        2:       m = 2'b11;
        default: m = 2'b01;
      endcase
      if (m != m_mode) do_wrmr(m);
      a = 16'($urandom);
      n = $urandom_range(1, 4);
      q_data.delete();
      for (int k = 0; k < n; k++) q_data.push_back(8'($urandom));
      do_write(a);
      do_read("rand", a, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
